// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencing controller.
// Defining ALARM_SNOOZE_EN adds the SNOOZE state to the encoding.
package alarm_pkg;

    localparam int unsigned SecWidth = 9;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSetMin  = 3'd1,
        StSetHour = 3'd2,
`ifdef ALARM_SNOOZE_EN
        StRing    = 3'd3,
        StSnooze  = 3'd4
`else
        StRing    = 3'd3
`endif
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;

    function automatic logic [1:0] sel_of_state(state_e st);
        case (st)
            StSetMin:  return SEL_MIN;
            StSetHour: return SEL_HOUR;
            default:   return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Key, time and alarm-set control signals between the controller and its surroundings.
interface alarm_controller_if;

    logic       tick_1hz;
    logic       key_mode;
    logic       key_adj;
    logic       key_ok;
    logic       alarm_on;
    logic [7:0] cur_hour;
    logic [7:0] cur_minute;
    logic [7:0] cur_second;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_minute;

    logic [1:0] alarm_set_select;
    logic       adj_en;
    logic       set_confirm;
    logic       setting;
    logic       ring;

    modport master (
        output tick_1hz, key_mode, key_adj, key_ok, alarm_on,
        output cur_hour, cur_minute, cur_second, alarm_hour, alarm_minute,
        input  alarm_set_select, adj_en, set_confirm, setting, ring
    );

    modport slave (
        input  tick_1hz, key_mode, key_adj, key_ok, alarm_on,
        input  cur_hour, cur_minute, cur_second, alarm_hour, alarm_minute,
        output alarm_set_select, adj_en, set_confirm, setting, ring
    );

endinterface

// File: rtl/alarm_sec_timer.sv
// Clearable 1 Hz second counter, saturating at the limit; done_o reflects the count
// including the tick of the current cycle so the caller can act on the limit-reaching tick.
module alarm_sec_timer
    import alarm_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                tick_i,
    input  logic [SecWidth-1:0] limit_i,
    output logic                done_o
);

    logic [SecWidth-1:0] count_q, count_d;
    logic [SecWidth:0]   count_next;

    assign count_next = {1'b0, count_q} + {{SecWidth{1'b0}}, tick_i};
    assign done_o     = (count_next >= {1'b0, limit_i});

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (tick_i && (count_q < limit_i)) begin
            count_d = count_next[SecWidth-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm set / ring sequencing FSM with one-trigger-per-minute match arming.
// Optional snooze state is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_controller #(
    parameter int unsigned RING_SECS        = 60,
    parameter int unsigned SNOOZE_SECS      = 300,
    parameter int unsigned SET_TIMEOUT_SECS = 30
) (
    input  logic               clk_i,
    input  logic               cr_i,
    alarm_controller_if.slave  bus
);
    import alarm_pkg::*;

    // IDLE has no timeout; let the counter run up to the longest interval there.
    localparam int unsigned LongA    = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int unsigned IdleSecs = (LongA > SET_TIMEOUT_SECS) ? LongA : SET_TIMEOUT_SECS;

    state_e state_q, state_d;
    logic       armed_q, armed_d;
    logic [1:0] sel_q, sel_d;
    logic       adj_en_q, adj_en_d;
    logic       confirm_q, confirm_d;
    logic       setting_q, setting_d;
    logic       ring_q, ring_d;

    logic [SecWidth-1:0] limit;
    logic timer_clr, timer_done;
    logic k_mode, k_ok, k_adj, any_key, in_set, match;

    assign k_mode  = bus.key_mode;
    assign k_ok    = bus.key_ok & ~bus.key_mode;
    assign k_adj   = bus.key_adj & ~bus.key_mode & ~bus.key_ok;
    assign any_key = bus.key_mode | bus.key_ok | bus.key_adj;
    assign in_set  = (state_q == StSetMin) || (state_q == StSetHour);
    assign match   = (bus.cur_hour == bus.alarm_hour) && (bus.cur_minute == bus.alarm_minute)
                     && (bus.cur_second == 8'h00);

    always_comb begin
        limit = SecWidth'(IdleSecs);
        case (state_q)
            StSetMin, StSetHour: limit = SecWidth'(SET_TIMEOUT_SECS);
            StRing:              limit = SecWidth'(RING_SECS);
`ifdef ALARM_SNOOZE_EN
            StSnooze:            limit = SecWidth'(SNOOZE_SECS);
`endif
            default:             limit = SecWidth'(IdleSecs);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        adj_en_d  = 1'b0;
        confirm_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (k_mode) begin
                    state_d = StSetMin;
                end else if (bus.alarm_on && armed_q && match) begin
                    state_d = StRing;
                    armed_d = 1'b0;
                end
            end
            StSetMin: begin
                if (k_mode) begin
                    state_d = StSetHour;
                end else if (k_ok) begin
                    state_d   = StSetHour;
                    confirm_d = 1'b1;
                end else if (k_adj) begin
                    adj_en_d = 1'b1;
                end else if (timer_done) begin
                    state_d = StIdle;
                end
            end
            StSetHour: begin
                if (k_mode) begin
                    state_d = StIdle;
                end else if (k_ok) begin
                    state_d   = StIdle;
                    confirm_d = 1'b1;
                end else if (k_adj) begin
                    adj_en_d = 1'b1;
                end else if (timer_done) begin
                    state_d = StIdle;
                end
            end
            StRing: begin
                if (k_mode || k_ok || !bus.alarm_on) begin
                    state_d = StIdle;
`ifdef ALARM_SNOOZE_EN
                end else if (k_adj) begin
                    state_d = StSnooze;
`endif
                end else if (timer_done) begin
                    state_d = StIdle;
                end
            end
`ifdef ALARM_SNOOZE_EN
            StSnooze: begin
                if (k_ok || !bus.alarm_on) begin
                    state_d = StIdle;
                end else if (timer_done) begin
                    state_d = StRing;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Re-arm only once the match window has passed; setting states leave it alone.
        if (!in_set && !match) begin
            armed_d = 1'b1;
        end

        sel_d     = confirm_d ? sel_q : sel_of_state(state_d);
        setting_d = (state_d == StSetMin) || (state_d == StSetHour);
        ring_d    = (state_d == StRing);
        timer_clr = (state_d != state_q) || (in_set && any_key);
    end

    alarm_sec_timer u_sec_timer (
        .clk_i   (clk_i),
        .rst_i   (cr_i),
        .clr_i   (timer_clr),
        .tick_i  (bus.tick_1hz),
        .limit_i (limit),
        .done_o  (timer_done)
    );

    always_ff @(posedge clk_i) begin
        if (cr_i) begin
            state_q   <= StIdle;
            armed_q   <= 1'b1;
            sel_q     <= SEL_NONE;
            adj_en_q  <= 1'b0;
            confirm_q <= 1'b0;
            setting_q <= 1'b0;
            ring_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            sel_q     <= sel_d;
            adj_en_q  <= adj_en_d;
            confirm_q <= confirm_d;
            setting_q <= setting_d;
            ring_q    <= ring_d;
        end
    end

    assign bus.alarm_set_select = sel_q;
    assign bus.adj_en           = adj_en_q;
    assign bus.set_confirm      = confirm_q;
    assign bus.setting          = setting_q;
    assign bus.ring             = ring_q;

endmodule

// File: doc/alarm_controller.md
# alarm_controller

Sequencing controller for the alarm-time datapath of the digital clock. Walks the user through setting the alarm minute and hour with the mode, adjust and confirm keys. Drives the select, count-enable and confirm inputs of the alarm time-set block. Compares alarm time against the running clock and sequences the ring / snooze cycle.

## Interface
- `RING_SECS`, 60: maximum ring duration in 1 Hz ticks.
- `SNOOZE_SECS`, 300: snooze interval in ticks; used only when snooze is compiled in.
- `SET_TIMEOUT_SECS`, 30: inactivity timeout in setting states.
- `clk` in 1: single system clock.
- `cr` in 1: reset, synchronous, active-high.
- `tick_1hz` in 1: one-`clk` pulse per second.
- `key_mode`, `key_adj`, `key_ok` in 1 each: debounced one-cycle key pulses.
- `alarm_on` in 1: alarm enable switch (level).
- `cur_hour`, `cur_minute`, `cur_second` in 8 each: running time, BCD.
- `alarm_hour`, `alarm_minute` in 8 each: stored alarm time, BCD.
- `alarm_set_select` out 2: 00 none, 01 minute, 10 hour.
- `adj_en` out 1: one-cycle count enable to the selected alarm counter.
- `set_confirm` out 1: one-cycle confirm pulse, qualified with `alarm_set_select`.
- `setting` out 1: high in SET_MIN / SET_HOUR; drives display blink.
- `ring` out 1: buzzer drive.

## Operation
- States: IDLE, SET_MIN, SET_HOUR, RING; plus SNOOZE when the macro is defined.
- Key priority within one cycle: `key_mode` > `key_ok` > `key_adj`. Lower-priority keys in the same cycle are dropped.
- IDLE:
  - `key_mode` -> SET_MIN.
  - Trigger -> RING. Trigger = `alarm_on` & `match_armed` & hour equal & minute equal & `cur_second`==8'h00.
- SET_MIN:
  - `key_adj` -> `adj_en` pulse.
  - `key_mode` -> SET_HOUR, no confirm.
  - `key_ok` -> `set_confirm` pulse with select 01, then SET_HOUR.
- SET_HOUR:
  - `key_adj` -> `adj_en` pulse.
  - `key_mode` -> IDLE, no confirm.
  - `key_ok` -> `set_confirm` pulse with select 10, then IDLE.
- Setting timeout: any key resets the inactivity counter. After `SET_TIMEOUT_SECS` ticks with no key -> IDLE, no confirm.
- RING:
  - `ring`=1.
  - `key_ok` -> IDLE.
  - `key_mode` -> IDLE; the key press is consumed and does not enter setting.
  - After `RING_SECS` ticks -> IDLE.
  - `alarm_on` falling -> IDLE in the next cycle.
- `match_armed` behaviour:
  - Cleared on trigger.
  - Set again only when the match condition is false.
  - Result: exactly one trigger per alarm minute, even if the ring is stopped during second 00.
- Alarm matches during SET_MIN / SET_HOUR are ignored; `match_armed` is untouched.
- Only one second counter exists (9 bits, sized for 300). It is cleared on every state entry and increments on `tick_1hz`.

## Timing
- All outputs are registered.
- Key pulse in cycle n -> new state, `alarm_set_select`, `setting`, `ring` visible in cycle n+1.
- `adj_en` and `set_confirm` are high exactly in cycle n+1, for one cycle.
- `set_confirm` coincides with the pre-transition select value. The select changes in cycle n+2.
- Trigger condition true in cycle n -> `ring`=1 in cycle n+1.
- Timeout: the tick that makes the counter reach the limit -> state change in the next cycle.
- `cr` in any cycle, including mid-ring or mid-set:
  - Next cycle: IDLE, select 00, all pulses 0, `ring`=0, `setting`=0, counter 0, `match_armed`=1.
- Key coinciding with `tick_1hz` at timeout: the key wins and the counter restarts.

## Configuration
- `ALARM_SNOOZE_EN` defined:
  - `key_adj` in RING -> SNOOZE (`ring`=0).
  - After `SNOOZE_SECS` ticks -> RING with a fresh ring counter.
  - `key_ok` or `alarm_on`=0 in SNOOZE -> IDLE.
  - Unlimited snooze repeats.
- `ALARM_SNOOZE_EN` undefined:
  - No SNOOZE state.
  - `key_adj` in RING is ignored.
  - `SNOOZE_SECS` is unused.

## Structure
- Package `alarm_pkg` holds:
  - State encoding constants.
  - Select codes SEL_NONE=2'b00, SEL_MIN=2'b01, SEL_HOUR=2'b10.
- Sub-module `alarm_sec_timer`:
  - Clear + `tick_1hz` counter.
  - Compare against a limit input.
  - Outputs a `done` level.
  - Instantiated once; the limit is muxed by state.
- The FSM and match logic stay in `alarm_controller`.

## Test plan
- Reset, then `key_mode`, `key_adj` ×3, `key_ok` -> select 01, three `adj_en` pulses, one `set_confirm` with select 01, then select 10 in the following cycle.
- In SET_HOUR, no keys for 30 ticks -> IDLE at tick 30, `set_confirm` never asserted, select 00.
- Alarm 07:30, `alarm_on`=1, clock reaches 07:30:00 -> `ring`=1 one cycle later. `key_ok` -> `ring`=0. No retrigger while the second stays 00.
- Ring unanswered -> `ring` drops after tick 60. Assert `cr` mid-ring -> `ring`=0 in the next cycle, `match_armed` restored.
- `key_mode` and `key_ok` in the same cycle in SET_MIN -> SET_HOUR, no `set_confirm`.
- With `ALARM_SNOOZE_EN`: `key_adj` in RING -> `ring`=0 for 300 ticks, then `ring`=1. Without the macro, the same stimulus leaves `ring`=1.
